rsa_roundtrip_check: RTL and testbench

//  Self-test sequencer that proves encrypt/decrypt round trip on one shared modular-exponentiation core.
//  On a start pulse it runs the encryption step, C = M^E mod N, and checks C against EXP_CIPHER.
//  It then runs the decryption step, P = C^D mod N, and checks P == M. The result goes to good/bad LEDs.
//  It is the initiator of the exponentiator start/end handshake and sits between the debounced push-button and the core.

---
 rtl/rsa_roundtrip_check.sv | 148 ++++++++++++++
 tb/tb_rsa_roundtrip_check.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_roundtrip_check.sv
// Round-trip self-test: encrypt MSG, check the ciphertext, decrypt it and check for MSG on one shared pow-mod core.
// me_start follows start by one cycle; good/bad follow the deciding me_end by one cycle; start is ignored while busy.
module rsa_roundtrip_check #(
   parameter int W          = 32,
   parameter int MSG        = 65,
   parameter int PUB_E      = 17,
   parameter int PRIV_D     = 2753,
   parameter int MODULUS    = 3233,
   parameter int EXP_CIPHER = 2790,
   parameter int TIMEOUT    = 100000,
   parameter int CW         = 24
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   output logic         me_start,
   output logic [W-1:0] me_base,
   output logic [W-1:0] me_exp,
   output logic [W-1:0] me_mod,
   input  logic         me_end,
   input  logic [W-1:0] me_r,
   output logic         busy,
   output logic         good,
   output logic         bad,
   output logic [1:0]   fail_code,
   output logic [W-1:0] cipher
);

   typedef enum logic [2:0] {IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           me_start_nxt, busy_nxt, good_nxt, bad_nxt;
   logic [1:0]     fail_code_nxt;
   logic [W-1:0]   base_nxt, exp_nxt, mod_nxt, cipher_nxt;
   logic           expired;

   // cnt is 0 in the me_start cycle, so expiry on TIMEOUT-1 puts bad exactly TIMEOUT cycles later
   assign expired = (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      me_start_nxt  = 1'b0;
      base_nxt      = me_base;
      exp_nxt       = me_exp;
      mod_nxt       = me_mod;
      good_nxt      = good;
      bad_nxt       = bad;
      fail_code_nxt = fail_code;
      cipher_nxt    = cipher;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt     = ENC_REQ;
               me_start_nxt  = 1'b1;
               base_nxt      = W'(MSG);
               exp_nxt       = W'(PUB_E);
               mod_nxt       = W'(MODULUS);
               good_nxt      = 1'b0;
               bad_nxt       = 1'b0;
               fail_code_nxt = 2'd0;
               cipher_nxt    = '0;
               cnt_nxt       = '0;
            end
         end
         ENC_REQ: begin
            state_nxt = ENC_WAIT;
            cnt_nxt   = cnt + CW'(1);
         end
         ENC_WAIT: begin
            if (me_end) begin
               cipher_nxt = me_r;
               if (me_r == W'(EXP_CIPHER)) begin
                  state_nxt    = DEC_REQ;
                  me_start_nxt = 1'b1;
                  base_nxt     = me_r;
                  exp_nxt      = W'(PRIV_D);
                  cnt_nxt      = '0;
               end else begin
                  state_nxt     = DONE;
                  bad_nxt       = 1'b1;
                  fail_code_nxt = 2'd1;
               end
            end else if (expired) begin
               state_nxt     = DONE;
               bad_nxt       = 1'b1;
               fail_code_nxt = 2'd3;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DEC_REQ: begin
            state_nxt = DEC_WAIT;
            cnt_nxt   = cnt + CW'(1);
         end
         DEC_WAIT: begin
            if (me_end) begin
               state_nxt = DONE;
               if (me_r == W'(MSG)) begin
                  good_nxt = 1'b1;
               end else begin
                  bad_nxt       = 1'b1;
                  fail_code_nxt = 2'd2;
               end
            end else if (expired) begin
               state_nxt     = DONE;
               bad_nxt       = 1'b1;
               fail_code_nxt = 2'd3;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == ENC_REQ) || (state_nxt == ENC_WAIT) ||
                 (state_nxt == DEC_REQ) || (state_nxt == DEC_WAIT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         me_start  <= 1'b0;
         me_base   <= '0;
         me_exp    <= '0;
         me_mod    <= '0;
         busy      <= 1'b0;
         good      <= 1'b0;
         bad       <= 1'b0;
         fail_code <= 2'd0;
         cipher    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         me_start  <= me_start_nxt;
         me_base   <= base_nxt;
         me_exp    <= exp_nxt;
         me_mod    <= mod_nxt;
         busy      <= busy_nxt;
         good      <= good_nxt;
         bad       <= bad_nxt;
         fail_code <= fail_code_nxt;
         cipher    <= cipher_nxt;
      end
   end

endmodule

// File: tb/tb_rsa_roundtrip_check.sv
// Bench for rsa_roundtrip_check: behavioural pow-mod stub with programmable latency and result overrides.
module tb_rsa_roundtrip_check;
   localparam int W  = 32;
   localparam int TO = 100;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         start = 1'b0;
   logic         me_start, busy, good, bad;
   logic         me_end = 1'b0;
   logic [W-1:0] me_r = '0;
   logic [W-1:0] me_base, me_exp, me_mod, cipher;
   logic [1:0]   fail_code;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int lat; int enc_ovr; int dec_ovr; bit no_end; bit extra;
      bit e_good; bit e_bad; int e_fc; int e_cipher; int e_starts; int e_delay;
   } case_t;

   // stub configuration (written by the test) and stub state (written by the stub only)
   int           cfg_lat = 10, cfg_enc = -1, cfg_dec = -1;
   bit           cfg_no_end = 1'b0;
   bit           inj_end = 1'b0;
   logic [W-1:0] inj_r = '0;
   bit           pend = 1'b0;
   int           rem = 0;
   longint       res = 0;
   int           st_n = 0;
   int           st_cyc [64];
   longint       st_base[64], st_exp[64], st_mod[64];

   rsa_roundtrip_check #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
      .me_end(me_end), .me_r(me_r),
      .busy(busy), .good(good), .bad(bad), .fail_code(fail_code), .cipher(cipher)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint powmod(input longint b, input longint e, input longint m);
      longint r = 1;
      b = b % m;
      while (e > 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >>> 1;
      end
      return r;
   endfunction

   // pow-mod core stand-in: me_end lands cfg_lat cycles after the me_start cycle
   always @(negedge clk) begin
      me_end = 1'b0;
      if (inj_end) begin
         me_end = 1'b1;
         me_r   = inj_r;
      end
      if (pend) begin
         rem = rem - 1;
         if (rem == 0) begin
            me_end = 1'b1;
            me_r   = W'(res);
            pend   = 1'b0;
         end
      end
      if (me_start) begin
         st_cyc[st_n % 64]  = cyc;
         st_base[st_n % 64] = longint'(me_base);
         st_exp[st_n % 64]  = longint'(me_exp);
         st_mod[st_n % 64]  = longint'(me_mod);
         st_n = st_n + 1;
         if (!cfg_no_end) begin
            pend = 1'b1;
            rem  = cfg_lat;
            if (me_exp == 17 && cfg_enc >= 0)        res = cfg_enc;
            else if (me_exp == 2753 && cfg_dec >= 0) res = cfg_dec;
            else res = powmod(longint'(me_base), longint'(me_exp), longint'(me_mod));
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // expected outcome of one run, from the encrypt/decrypt rules
   function automatic case_t model(input case_t c);
      case_t  o = c;
      longint r1, r2;
      r1 = (c.enc_ovr >= 0) ? longint'(c.enc_ovr) : powmod(65, 17, 3233);
      o.e_good = 0; o.e_bad = 1; o.e_delay = c.lat + 1;
      if (c.no_end || c.lat >= TO) begin
         o.e_fc = 3; o.e_cipher = 0; o.e_starts = 1; o.e_delay = TO;
      end else if (r1 != 2790) begin
         o.e_fc = 1; o.e_cipher = int'(r1); o.e_starts = 1;
      end else begin
         r2 = (c.dec_ovr >= 0) ? longint'(c.dec_ovr) : powmod(r1, 2753, 3233);
         o.e_cipher = 2790; o.e_starts = 2;
         if (r2 == 65) begin o.e_good = 1; o.e_bad = 0; o.e_fc = 0; end
         else o.e_fc = 2;
      end
      return o;
   endfunction

   task automatic inject_end(input logic [W-1:0] r);
      @(posedge clk);
      inj_r = r; inj_end = 1'b1;
      @(posedge clk);
      inj_end = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_case(input case_t c, input string tag);
      int mark, done_cyc, n, last;
      cfg_lat = c.lat; cfg_enc = c.enc_ovr; cfg_dec = c.dec_ovr; cfg_no_end = c.no_end;
      mark = st_n;
      done_cyc = -1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk({tag, "_mestart"}, me_start, 1);
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_clr"}, {good, bad, fail_code}, 0);
      chk({tag, "_clr_cipher"}, cipher, 0);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (good || bad) begin
            done_cyc = cyc;
            break;
         end
         start = c.extra && (k == 4 || k == 8);
      end
      start = 1'b0;
      chk({tag, "_finished"}, good | bad, 1);
      repeat (3) @(negedge clk);
      n = st_n - mark;
      last = (st_n - 1) % 64;
      chk({tag, "_good"}, good, c.e_good);
      chk({tag, "_bad"}, bad, c.e_bad);
      chk({tag, "_fail_code"}, fail_code, c.e_fc);
      chk({tag, "_cipher"}, cipher, c.e_cipher);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_exclusive"}, good & bad, 0);
      chk({tag, "_starts"}, n, c.e_starts);
      chk({tag, "_enc_ops"}, {st_base[mark % 64][15:0], st_exp[mark % 64][15:0], st_mod[mark % 64][15:0]},
          {16'd65, 16'd17, 16'd3233});
      if (n >= 2)
         chk({tag, "_dec_ops"}, {st_base[(mark + 1) % 64][15:0], st_exp[(mark + 1) % 64][15:0],
             st_mod[(mark + 1) % 64][15:0]}, {16'd2790, 16'd2753, 16'd3233});
      chk({tag, "_delay"}, done_cyc - st_cyc[last], c.e_delay);
   endtask

   case_t tbl[8];
   case_t rc;

   initial begin
      //            lat  enc   dec  noend extra good bad fc cipher starts delay
      tbl[0] = '{   40,   -1,   -1, 0, 0,  1, 0, 0, 2790, 2, 41 };
      tbl[1] = '{   40, 2791,   -1, 0, 0,  0, 1, 1, 2791, 1, 41 };
      tbl[2] = '{   40,   -1,   66, 0, 0,  0, 1, 2, 2790, 2, 41 };
      tbl[3] = '{   40,   -1,   -1, 1, 0,  0, 1, 3,    0, 1, TO };
      tbl[4] = '{ TO-1,   -1,   -1, 0, 0,  1, 0, 0, 2790, 2, TO };
      tbl[5] = '{   TO,   -1,   -1, 0, 0,  0, 1, 3,    0, 1, TO };
      tbl[6] = '{   30,   -1,   -1, 0, 1,  1, 0, 0, 2790, 2, 31 };
      tbl[7] = '{    1,   -1,    0, 0, 0,  0, 1, 2, 2790, 2,  2 };

      #2 rstn = 1'b0;
      #1;
      chk("rst_ctrl", {me_start, busy, good, bad, fail_code}, 0);
      chk("rst_ops", {me_base, me_exp, me_mod, cipher}, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      inject_end(32'd2790);
      chk("idle_stray_end", {busy, good, bad, fail_code}, 0);
      chk("idle_stray_cipher", cipher, 0);
      chk("idle_stray_starts", st_n, 0);
      chk("idle_ops_zero", {me_base, me_exp, me_mod}, 0);

      for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("t%0d", i));

      inject_end(32'd65);
      chk("done_stray_flags", {good, bad, fail_code}, {1'b0, 1'b1, 2'd2});
      chk("done_stray_cipher", cipher, 2790);

      begin
         int mark;
         cfg_lat = 40; cfg_enc = -1; cfg_dec = -1; cfg_no_end = 0;
         mark = st_n;
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         repeat (10) @(negedge clk);
         chk("mid_busy", busy, 1);
         rstn = 1'b0;
         #1;
         chk("mid_rst_ctrl", {me_start, busy, good, bad, fail_code}, 0);
         chk("mid_rst_ops", {me_base, me_exp, me_mod, cipher}, 0);
         repeat (3) @(negedge clk);
         rstn = 1'b1;
         for (int k = 0; k < 60 && pend; k++) @(negedge clk);
         chk("mid_stub_drained", pend, 0);
         repeat (3) @(negedge clk);
         chk("mid_stale_ignored", {busy, good, bad, fail_code}, 0);
         chk("mid_stale_cipher", cipher, 0);
         chk("mid_starts", st_n - mark, 1);
      end
      run_case(tbl[0], "fresh");

      for (int i = 0; i < 8; i++) begin
         rc.lat     = int'($urandom_range(1, 60));
         rc.enc_ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3232)) : -1;
         rc.dec_ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3232)) : -1;
         rc.no_end  = 1'b0;
         rc.extra   = 1'($urandom_range(0, 1));
         run_case(model(rc), $sformatf("r%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
